ds_bilinear_window_fetch: RTL

- Upstream feeder for the bilinear downsample PE.
- Accepts a raster pixel stream into two ping-pong line buffers and walks the output grid in fixed-point source coordinates.
- For each output pixel, emits the 2x2 neighbourhood (a00/a01/a10/a11) plus fixed-point index and origin values, in exactly the format the PE consumes.
- One result per cycle under valid/ready backpressure.

---
 rtl/ds_bilinear_window_fetch_pkg.sv | 30 +++
 rtl/ds_bilinear_window_fetch_line_buffer.sv | 28 ++
 rtl/ds_bilinear_window_fetch.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ds_bilinear_window_fetch_pkg.sv
// Shared widths, FSM encoding and fixed-point helpers for the bilinear window fetcher.
package ds_pkg;

  localparam int DS_AWIDTH = 11;
  localparam int DS_EXTEND = 30;
  localparam int DS_DWIDTH = 8;
  localparam int DS_MAX_W  = 2048;
  localparam int DS_FWIDTH = DS_AWIDTH + DS_EXTEND;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_EMIT,
    S_DONE
  } ds_state_t;

  // Integer part of a fixed-point coordinate, limited to the last valid index.
  function automatic logic [DS_AWIDTH-1:0] floor_clamp(input logic [DS_FWIDTH-1:0] coord,
                                                       input logic [DS_AWIDTH-1:0] last);
    logic [DS_AWIDTH-1:0] fl;
    fl = coord[DS_FWIDTH-1:DS_EXTEND];
    return (fl > last) ? last : fl;
  endfunction

  function automatic logic [DS_AWIDTH-1:0] next_clamp(input logic [DS_AWIDTH-1:0] idx,
                                                      input logic [DS_AWIDTH-1:0] last);
    return (idx >= last) ? last : idx + DS_AWIDTH'(1);
  endfunction

endpackage

// File: rtl/ds_bilinear_window_fetch_line_buffer.sv
// One row of pixels: a single write port and two asynchronous read ports (x0 and x1).
module ds_line_buffer
  import ds_pkg::*;
#(
  parameter int DEPTH = DS_MAX_W,
  parameter int AW    = DS_AWIDTH,
  parameter int DW    = DS_DWIDTH
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr0,
  output logic [DW-1:0] rd_data0,
  input  logic [AW-1:0] rd_addr1,
  output logic [DW-1:0] rd_data1
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/ds_bilinear_window_fetch.sv
// Upstream feeder for the bilinear downsample PE: fills ping-pong row buffers from a
// raster stream and emits one registered 2x2 neighbourhood per output pixel.
module ds_bilinear_window_fetch
  import ds_pkg::*;
#(
  parameter int AWIDTH = DS_AWIDTH,
  parameter int EXTEND = DS_EXTEND,
  parameter int DWIDTH = DS_DWIDTH,
  parameter int MAX_W  = DS_MAX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [AWIDTH-1:0]        cfg_in_w,
  input  logic [AWIDTH-1:0]        cfg_in_h,
  input  logic [AWIDTH-1:0]        cfg_out_w,
  input  logic [AWIDTH-1:0]        cfg_out_h,
  input  logic [AWIDTH+EXTEND-1:0] cfg_step_col,
  input  logic [AWIDTH+EXTEND-1:0] cfg_step_row,
  input  logic                     in_valid,
  input  logic [DWIDTH-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DWIDTH-1:0]        a00,
  output logic [DWIDTH-1:0]        a01,
  output logic [DWIDTH-1:0]        a10,
  output logic [DWIDTH-1:0]        a11,
  output logic [AWIDTH+EXTEND-1:0] index_row,
  output logic [AWIDTH+EXTEND-1:0] index_col,
  output logic [AWIDTH+EXTEND-1:0] index_row_origin,
  output logic [AWIDTH+EXTEND-1:0] index_col_origin,
  output logic                     done
);

  localparam int FW = AWIDTH + EXTEND;
  localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

  ds_state_t state, state_next;

  logic [AWIDTH-1:0] in_w, in_h, out_w, out_h;
  logic [FW-1:0]     step_col, step_row;
  logic [AWIDTH-1:0] c, r, oy, ox;
  logic [FW-1:0]     ys, xs, ys_nx;

  logic [AWIDTH-1:0] in_w_m1, in_h_m1, r_done, oy_nx;
  logic [AWIDTH-1:0] y0, y1, y1_nx, x0, x1;
  logic              in_fire, row_last_px, col_pending, load_en, emit_row_end;
  logic [DWIDTH-1:0] b0_x0, b0_x1, b1_x0, b1_x1;

  assign in_w_m1 = in_w - ONE;
  assign in_h_m1 = in_h - ONE;
  assign r_done  = r - ONE;
  assign oy_nx   = oy + ONE;
  assign ys_nx   = ys + step_row;

  assign y0    = floor_clamp(ys, in_h_m1);
  assign y1    = next_clamp(y0, in_h_m1);
  assign y1_nx = next_clamp(floor_clamp(ys_nx, in_h_m1), in_h_m1);
  assign x0    = floor_clamp(xs, in_w_m1);
  assign x1    = next_clamp(x0, in_w_m1);

  assign in_fire      = in_valid && (state == S_FILL);
  assign row_last_px  = in_fire && (c == in_w_m1);
  assign col_pending  = (ox != out_w);
  assign load_en      = !out_valid || out_ready;
  assign emit_row_end = (state == S_EMIT) && !col_pending && out_valid && out_ready;

  // Row r lives in buffer r[0]; both buffers expose x0 and x1 reads.
  ds_line_buffer #(.DEPTH(MAX_W), .AW(AWIDTH), .DW(DWIDTH)) u_buf0 (
    .clk(clk), .wr_en(in_fire && !r[0]), .wr_addr(c), .wr_data(in_data),
    .rd_addr0(x0), .rd_data0(b0_x0), .rd_addr1(x1), .rd_data1(b0_x1)
  );

  ds_line_buffer #(.DEPTH(MAX_W), .AW(AWIDTH), .DW(DWIDTH)) u_buf1 (
    .clk(clk), .wr_en(in_fire && r[0]), .wr_addr(c), .wr_data(in_data),
    .rd_addr0(x0), .rd_data0(b1_x0), .rd_addr1(x1), .rd_data1(b1_x1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // While emitting, r counts completed rows, so the newest row held is r-1.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_FILL;
      S_FILL: begin
        in_ready = 1'b1;
        if (row_last_px) begin
          if ((oy < out_h) && (y1 == r)) state_next = S_EMIT;
          else if (r == in_h_m1)         state_next = S_DONE;
        end
      end
      S_EMIT: begin
        if (emit_row_end) begin
          if ((oy_nx == out_h) && (r_done == in_h_m1))    state_next = S_DONE;
          else if ((oy_nx < out_h) && (y1_nx <= r_done)) state_next = S_EMIT;
          else                                            state_next = S_FILL;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_w     <= '0;
      in_h     <= '0;
      out_w    <= '0;
      out_h    <= '0;
      step_col <= '0;
      step_row <= '0;
      c        <= '0;
      r        <= '0;
      oy       <= '0;
      ox       <= '0;
      ys       <= '0;
      xs       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            in_w     <= cfg_in_w;
            in_h     <= cfg_in_h;
            out_w    <= cfg_out_w;
            out_h    <= cfg_out_h;
            step_col <= cfg_step_col;
            step_row <= cfg_step_row;
            c        <= '0;
            r        <= '0;
            oy       <= '0;
            ox       <= '0;
            ys       <= '0;
            xs       <= '0;
          end
        end
        S_FILL: begin
          if (in_fire) begin
            if (c == in_w_m1) begin
              c <= '0;
              r <= r + ONE;
            end else begin
              c <= c + ONE;
            end
          end
        end
        S_EMIT: begin
          if (load_en && col_pending) begin
            ox <= ox + ONE;
            xs <= xs + step_col;
          end
          if (emit_row_end) begin
            ox <= '0;
            xs <= '0;
            oy <= oy_nx;
            ys <= ys_nx;
          end
        end
        default: ;
      endcase
    end
  end

  // Output bundle register; it only advances when empty or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      a00              <= '0;
      a01              <= '0;
      a10              <= '0;
      a11              <= '0;
      index_row        <= '0;
      index_col        <= '0;
      index_row_origin <= '0;
      index_col_origin <= '0;
    end else if ((state == S_EMIT) && load_en) begin
      out_valid <= col_pending;
      if (col_pending) begin
        a00              <= y0[0] ? b1_x0 : b0_x0;
        a01              <= y0[0] ? b1_x1 : b0_x1;
        a10              <= y1[0] ? b1_x0 : b0_x0;
        a11              <= y1[0] ? b1_x1 : b0_x1;
        index_row        <= ys;
        index_col        <= xs;
        index_row_origin <= {y0, {EXTEND{1'b0}}};
        index_col_origin <= {x0, {EXTEND{1'b0}}};
      end
    end
  end

endmodule
